// File: rtl/ri_estendido.sv
// ri_estendido: SAP instruction register with short/long instructions and a registered data address.
// Ports:
//   CLK, CLR (async, active-low) - clock and reset
//   Li, Ei (active-low)          - load strobe, address-output enable
//   ciclo_busca                  - fetch phase; loads are accepted only while high
//   barramento_w                 - bus W carrying instruction and operand words
//   consumir                     - control unit has taken the held instruction
//   op_code, endereco_dado       - captured opcode, registered zero-extended data address
//   instr_pronta, instr_longa,
//   aguardando_op                - state/status decodes
//   erro_sobrescrita             - sticky: load attempted while an instruction was held
module ri_estendido #(
  parameter int LARGURA_BARRAMENTO = 8,
  parameter int LARGURA_OPCODE = 4,
  parameter int LARGURA_ENDERECO = 4,
  parameter logic [LARGURA_OPCODE-1:0] OPCODE_LONGO_MIN = 4'hC
) (
  input  logic CLK,
  input  logic CLR,
  input  logic Li,
  input  logic Ei,
  input  logic ciclo_busca,
  input  logic [LARGURA_BARRAMENTO-1:0] barramento_w,
  input  logic consumir,
  output logic [LARGURA_OPCODE-1:0] op_code,
  output logic [LARGURA_ENDERECO+LARGURA_BARRAMENTO-1:0] endereco_dado,
  output logic instr_pronta,
  output logic instr_longa,
  output logic aguardando_op,
  output logic erro_sobrescrita
);
  if (LARGURA_OPCODE + LARGURA_ENDERECO != LARGURA_BARRAMENTO) begin : g_chk
    $error("ri_estendido: LARGURA_OPCODE + LARGURA_ENDERECO must equal LARGURA_BARRAMENTO");
  end
  localparam logic [1:0] VAZIO = 2'd0;
  localparam logic [1:0] AGUARDA_OPERANDO = 2'd1;
  localparam logic [1:0] PRONTA = 2'd2;
  logic [1:0] estado;
  logic [LARGURA_ENDERECO-1:0] addr_int;
  logic [LARGURA_BARRAMENTO-1:0] operando_int;
  logic carga, captura, longo;
  assign carga = !Li && ciclo_busca;
  // A new opcode is taken when empty, or back-to-back when the held one is consumed on the same edge.
  assign captura = carga && (estado == VAZIO || (estado == PRONTA && consumir));
  assign longo = barramento_w[LARGURA_OPCODE-1:0] >= OPCODE_LONGO_MIN;
  assign instr_pronta = estado == PRONTA;
  assign aguardando_op = estado == AGUARDA_OPERANDO;
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      estado <= VAZIO;
      op_code <= '0;
      addr_int <= '0;
      operando_int <= '0;
      instr_longa <= 1'b0;
      erro_sobrescrita <= 1'b0;
      endereco_dado <= '0;
    end else begin
      if (captura) begin
        op_code <= barramento_w[LARGURA_OPCODE-1:0];
        addr_int <= barramento_w[LARGURA_BARRAMENTO-1:LARGURA_OPCODE];
        instr_longa <= longo;
        estado <= longo ? AGUARDA_OPERANDO : PRONTA;
      end else if (estado == AGUARDA_OPERANDO && carga) begin
        operando_int <= barramento_w;
        estado <= PRONTA;
      end else if (estado == PRONTA && consumir) begin
        instr_longa <= 1'b0;
        estado <= VAZIO;
      end else if (estado == PRONTA && carga) begin
        erro_sobrescrita <= 1'b1;
      end
      // Reads the registers as they were before this edge, so a same-edge consume uses the held instruction.
      if (!Ei && estado == PRONTA)
        endereco_dado <= instr_longa ? {operando_int, addr_int} : {{LARGURA_BARRAMENTO{1'b0}}, addr_int};
    end
  end
endmodule

// File: tb/tb_ri_estendido.sv
// tb_ri_estendido: scoreboard bench for ri_estendido with directed vectors.
module tb_ri_estendido;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  logic Li = 1'b0;
  logic Ei = 1'b1;
  logic ciclo_busca = 1'b1;
  logic [7:0] barramento_w = 8'hFF;
  logic consumir = 1'b0;
  logic [3:0] op_code;
  logic [11:0] endereco_dado;
  logic instr_pronta, instr_longa, aguardando_op, erro_sobrescrita;
  typedef struct packed {
    logic [3:0] op;
    logic [11:0] ende;
    logic pr;
    logic lo;
    logic ag;
    logic er;
  } exp_t;
  exp_t q[$];
  event chk_ev;
  int checks = 0;
  int errors = 0;
  int n = 0;
  ri_estendido dut (
    .CLK(CLK), .CLR(CLR), .Li(Li), .Ei(Ei), .ciclo_busca(ciclo_busca),
    .barramento_w(barramento_w), .consumir(consumir), .op_code(op_code),
    .endereco_dado(endereco_dado), .instr_pronta(instr_pronta), .instr_longa(instr_longa),
    .aguardando_op(aguardando_op), .erro_sobrescrita(erro_sobrescrita)
  );
  always #5 CLK = ~CLK;
  function automatic exp_t mk(logic [3:0] op, logic [11:0] ende, logic pr, logic lo, logic ag, logic er);
    mk = '{op: op, ende: ende, pr: pr, lo: lo, ag: ag, er: er};
  endfunction
  task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or chk_ev);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n++;
        chk("op_code", n, {8'h0, op_code}, {8'h0, e.op});
        chk("endereco_dado", n, endereco_dado, e.ende);
        chk("instr_pronta", n, {11'h0, instr_pronta}, {11'h0, e.pr});
        chk("instr_longa", n, {11'h0, instr_longa}, {11'h0, e.lo});
        chk("aguardando_op", n, {11'h0, aguardando_op}, {11'h0, e.ag});
        chk("erro_sobrescrita", n, {11'h0, erro_sobrescrita}, {11'h0, e.er});
      end
    end
  end
  task automatic step(input logic clr, input logic li, input logic ei, input logic cb,
                      input logic [7:0] bus, input logic cons, input exp_t e);
    @(negedge CLK);
    CLR = clr; Li = li; Ei = ei; ciclo_busca = cb; barramento_w = bus; consumir = cons;
    q.push_back(e);
  endtask
  task automatic async_reset(input exp_t e);
    @(negedge CLK);
    CLR = 1'b0;
    q.push_back(e);
    -> chk_ev;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end
  initial begin
    //      CLR  Li   Ei   cb   bus    cons  expected: op  addr   pr lo ag er
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, mk(4'h0, 12'h000, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, mk(4'h0, 12'h000, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, mk(4'hA, 12'h000, 1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, mk(4'hA, 12'h005, 1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, mk(4'hA, 12'h005, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h3D, 1'b0, mk(4'hD, 12'h005, 0, 1, 1, 0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, mk(4'hD, 12'h005, 0, 1, 1, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h9E, 1'b0, mk(4'hD, 12'h005, 1, 1, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, mk(4'hD, 12'h9E3, 1, 1, 0, 0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, mk(4'hD, 12'h9E3, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h62, 1'b0, mk(4'h2, 12'h9E3, 1, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h71, 1'b0, mk(4'h2, 12'h9E3, 1, 0, 0, 1));
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, mk(4'h2, 12'h006, 0, 0, 0, 1));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h83, 1'b0, mk(4'h3, 12'h006, 1, 0, 0, 1));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h4C, 1'b1, mk(4'hC, 12'h006, 0, 1, 1, 1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, mk(4'hC, 12'h006, 0, 1, 1, 1));
    async_reset(mk(4'h0, 12'h000, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, mk(4'h0, 12'h000, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, mk(4'h0, 12'h000, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hE7, 1'b0, mk(4'h7, 12'h000, 1, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, mk(4'h7, 12'h00E, 1, 0, 0, 0));
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
